// File: rtl/instr_fetch.sv
// Fetch stage: program counter and run sequencer (IDLE/LOAD/RUN/DONE)
// feeding the instruction ROM address and consuming decoder BranchEn/Ack.
// Optional feature macro: FETCH_CYCLE_COUNT_EN adds a saturating 16-bit
// RUN-cycle counter on cycle_count_o.
module instr_fetch #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            branch_en_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            ack_i,
  output logic [PC_W-1:0] prog_ctr_o,
  output logic            running_o,
  output logic            done_o
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]     cycle_count_o
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  // State, PC and status flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Next-state / next-PC; status flags follow the next state so they are registered
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          pc_d    = START_PC;
        end
      end
      S_LOAD: begin
        pc_d = START_PC;
        if (!start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_i) begin
          state_d = S_LOAD;
          pc_d    = START_PC;
        end else if (stall_i) begin
          state_d = S_RUN;
        end else if (ack_i) begin
          // halt: PC stays parked on the halt instruction
          state_d = S_DONE;
        end else if (branch_en_i) begin
          pc_d = branch_target_i;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          pc_d    = START_PC;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
      end
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  assign prog_ctr_o = pc_q;
  assign running_o  = running_q;
  assign done_o     = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycle counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Clear in LOAD, count every RUN cycle (stalls included), saturate, hold elsewhere
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LOAD) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cycle_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected PC/status pushed on a scoreboard
// queue with each stimulus step, popped and compared after the clock edge.
module tb_instr_fetch;

  localparam int unsigned PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            stall;
  logic            br_en;
  logic [PC_W-1:0] br_tgt;
  logic            ack;
  logic [PC_W-1:0] pc;
  logic            running;
  logic            done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]     cnt;
`endif

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            run;
    logic            done;
    string           tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  instr_fetch #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .stall_i        (stall),
    .branch_en_i    (br_en),
    .branch_target_i(br_tgt),
    .ack_i          (ack),
    .prog_ctr_o     (pc),
    .running_o      (running),
    .done_o         (done)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count_o  (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [PC_W-1:0] epc, input logic er, input logic ed);
    chk({tag, ".pc"},   32'(pc),      32'(epc));
    chk({tag, ".run"},  32'(running), 32'(er));
    chk({tag, ".done"}, 32'(done),    32'(ed));
  endtask

  // One clock: drive inputs, push expectation, sample #1 after the edge
  task automatic cyc(input string tag, input logic st, input logic sl, input logic br,
                     input logic [PC_W-1:0] tgt, input logic ak,
                     input logic [PC_W-1:0] epc, input logic er, input logic ed);
    exp_t e;
    start  = st;
    stall  = sl;
    br_en  = br;
    br_tgt = tgt;
    ack    = ak;
    sb.push_back('{pc: epc, run: er, done: ed, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(e.tag, e.pc, e.run, e.done);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; br_en = 1'b0; br_tgt = '0; ack = 1'b0;
    #12;
    chk_all("reset", 10'h000, 1'b0, 1'b0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("reset.cnt", 32'(cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // load and sequential run
    cyc("idle2load",  1, 0, 0, 10'h000, 0, 10'h000, 0, 0);
    cyc("load_hold",  1, 0, 0, 10'h000, 0, 10'h000, 0, 0);
    cyc("run_first",  0, 0, 0, 10'h000, 0, 10'h000, 1, 0);
    cyc("seq1",       0, 0, 0, 10'h000, 0, 10'h001, 1, 0);
    cyc("seq2",       0, 0, 0, 10'h000, 0, 10'h002, 1, 0);
    cyc("seq3",       0, 0, 0, 10'h000, 0, 10'h003, 1, 0);

    // branch
    cyc("branch",     0, 0, 1, 10'h155, 0, 10'h155, 1, 0);
    cyc("post_br",    0, 0, 0, 10'h000, 0, 10'h156, 1, 0);

    // stall for 3 cycles, decoder inputs ignored
    cyc("stall1",     0, 1, 0, 10'h000, 0, 10'h156, 1, 0);
    cyc("stall2",     0, 1, 1, 10'h2AA, 0, 10'h156, 1, 0);
    cyc("stall3",     0, 1, 1, 10'h2AA, 1, 10'h156, 1, 0);
    cyc("post_stall", 0, 0, 0, 10'h000, 0, 10'h157, 1, 0);

    // halt at PC=7, DONE ignores decoder/stall
    cyc("br_to_7",    0, 0, 1, 10'h007, 0, 10'h007, 1, 0);
    cyc("ack_at_7",   0, 0, 0, 10'h000, 1, 10'h007, 0, 1);
    cyc("done_br",    0, 0, 1, 10'h123, 0, 10'h007, 0, 1);
    cyc("done_misc",  0, 1, 1, 10'h045, 1, 10'h007, 0, 1);

    // restart from DONE
    cyc("done2load",  1, 0, 0, 10'h000, 0, 10'h000, 0, 0);
    cyc("rerun",      0, 0, 0, 10'h000, 0, 10'h000, 1, 0);

    // wrap at all-ones
    cyc("br_3fe",     0, 0, 1, 10'h3FE, 0, 10'h3FE, 1, 0);
    cyc("to_3ff",     0, 0, 0, 10'h000, 0, 10'h3FF, 1, 0);
    cyc("wrap0",      0, 0, 0, 10'h000, 0, 10'h000, 1, 0);
    cyc("wrap1",      0, 0, 0, 10'h000, 0, 10'h001, 1, 0);

    // abort mid-run at PC=20
    cyc("br_to_20",   0, 0, 1, 10'h014, 0, 10'h014, 1, 0);
    cyc("abort",      1, 0, 0, 10'h000, 0, 10'h000, 0, 0);
    cyc("abort_run",  0, 0, 0, 10'h000, 0, 10'h000, 1, 0);

    // Ack beats BranchEn
    cyc("pre_ackbr",  0, 0, 0, 10'h000, 0, 10'h001, 1, 0);
    cyc("ack_and_br", 0, 0, 1, 10'h2AA, 1, 10'h001, 0, 1);
    cyc("ackbr_hold", 0, 0, 0, 10'h000, 0, 10'h001, 0, 1);

    // cycle-count run: 5 RUN cycles including one stall, then Ack
    cyc("cc_load",    1, 0, 0, 10'h000, 0, 10'h000, 0, 0);
    cyc("cc_run0",    0, 0, 0, 10'h000, 0, 10'h000, 1, 0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cc_start.cnt", 32'(cnt), 32'd0);
`endif
    cyc("cc_r1",      0, 0, 0, 10'h000, 0, 10'h001, 1, 0);
    cyc("cc_stall",   0, 1, 0, 10'h000, 0, 10'h001, 1, 0);
    cyc("cc_r3",      0, 0, 0, 10'h000, 0, 10'h002, 1, 0);
    cyc("cc_r4",      0, 0, 0, 10'h000, 0, 10'h003, 1, 0);
    cyc("cc_r5",      0, 0, 0, 10'h000, 0, 10'h004, 1, 0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cc_r5.cnt", 32'(cnt), 32'd5);
`endif
    cyc("cc_ack",     0, 0, 0, 10'h000, 1, 10'h004, 0, 1);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cc_ack.cnt", 32'(cnt), 32'd6);
`endif
    cyc("cc_hold",    0, 1, 1, 10'h100, 0, 10'h004, 0, 1);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cc_hold.cnt", 32'(cnt), 32'd6);
`endif

    // asynchronous reset mid-run
    cyc("rst_load",   1, 0, 0, 10'h000, 0, 10'h000, 0, 0);
    cyc("rst_run0",   0, 0, 0, 10'h000, 0, 10'h000, 1, 0);
    cyc("rst_run1",   0, 0, 0, 10'h000, 0, 10'h001, 1, 0);
    cyc("rst_run2",   0, 0, 0, 10'h000, 0, 10'h002, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 10'h000, 1'b0, 1'b0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("async_rst.cnt", 32'(cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("post_rst",   0, 1, 1, 10'h0AA, 1, 10'h000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
